// File: rtl/pat_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : pat_stream_out
// Description : Streams one camera pattern per pat_req from the 64-bit DDR2
//               output FIFO as 16-bit mask beats, four beats per word and
//               eight words per row. It also tracks the pattern index across
//               a Num_Pat+2 pattern sequence and pulses seq_done when the
//               final pattern of the sequence has been sent.
// Ports       : clk, fsm_rst_n (async active-low), Num_Pat, pat_req
//               outfifo_dout/outfifo_empty/outfifo_rd_en : FIFO read side
//               mask_data/mask_valid/row_addr/row_strobe : beat stream
//               pat_busy, pat_idx, seq_done              : sequence status
//               err_underrun, err_req_busy               : sticky errors
//               row_parity (only with ROW_PARITY_EN)     : XOR of row beats
// Options     : define ROW_PARITY_EN to add the row_parity output.
// Revision    : 1.0 - initial release
// ============================================================================
module pat_stream_out #(
    parameter int ROWS           = 176,
    parameter int WORDS_PER_ROW  = 8,
    parameter int BEATS_PER_WORD = 4     // a 64-bit word holds exactly 4 beats
) (
    input  logic        clk,
    input  logic        fsm_rst_n,
    input  logic [31:0] Num_Pat,
    input  logic        pat_req,
    input  logic [63:0] outfifo_dout,
    input  logic        outfifo_empty,
    output logic        outfifo_rd_en,
    output logic [15:0] mask_data,
    output logic        mask_valid,
    output logic [7:0]  row_addr,
    output logic        row_strobe,
    output logic        pat_busy,
    output logic [31:0] pat_idx,
    output logic        seq_done,
    output logic        err_underrun,
    output logic        err_req_busy
`ifdef ROW_PARITY_EN
    ,
    output logic [15:0] row_parity
`endif
);

    localparam logic [2:0] c_LAST_WORD = 3'(WORDS_PER_ROW - 1);
    localparam logic [7:0] c_LAST_ROW  = 8'(ROWS - 1);
    localparam logic [1:0] c_LAST_BEAT = 2'(BEATS_PER_WORD - 1);
    // Prefetch one beat before the end so the FIFO data is ready for the
    // word switch without a bubble.
    localparam logic [1:0] c_PREF_BEAT = 2'(BEATS_PER_WORD - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [63:0] r_word_reg;
    logic [1:0]  r_beat_cnt;
    logic [2:0]  r_word_cnt;     // word being shifted or fetched
    logic [7:0]  r_row_cnt;
    logic        r_prefetched;   // next word was read during beat 2
    logic [31:0] r_pat_idx;
    logic        r_pat_busy;
    logic        r_seq_done;
    logic        r_err_underrun;
    logic        r_err_req_busy;

    logic        w_in_shift;
    logic        w_last_word_of_row;
    logic        w_last_word_of_pat;
    logic        w_first_word;
    logic        w_fetch_rd;
    logic        w_prefetch_rd;
    logic [15:0] w_beat;
    logic        w_last_pat;     // pattern now finishing ends the sequence
    logic        w_seq_complete; // previous sequence fully sent

    // 33-bit comparisons so Num_Pat near 0xFFFFFFFF never wraps.
    assign w_last_pat     = ({1'b0, r_pat_idx} == ({1'b0, Num_Pat} + 33'd1));
    assign w_seq_complete = ({1'b0, r_pat_idx} == ({1'b0, Num_Pat} + 33'd2));

    assign w_in_shift         = (r_state == S_SHIFT);
    assign w_last_word_of_row = (r_word_cnt == c_LAST_WORD);
    assign w_last_word_of_pat = w_last_word_of_row && (r_row_cnt == c_LAST_ROW);
    assign w_first_word       = (r_word_cnt == 3'd0) && (r_row_cnt == 8'd0);

    assign w_fetch_rd    = (r_state == S_FETCH) && !outfifo_empty;
    assign w_prefetch_rd = w_in_shift && (r_beat_cnt == c_PREF_BEAT)
                           && !w_last_word_of_pat && !outfifo_empty;

    // Beat 0 is the most significant halfword.
    always_comb begin
        w_beat = r_word_reg[63:48];
        case (r_beat_cnt)
            2'd0:    w_beat = r_word_reg[63:48];
            2'd1:    w_beat = r_word_reg[47:32];
            2'd2:    w_beat = r_word_reg[31:16];
            default: w_beat = r_word_reg[15:0];
        endcase
    end

    assign outfifo_rd_en = w_fetch_rd | w_prefetch_rd;
    assign mask_valid    = w_in_shift;
    assign mask_data     = w_in_shift ? w_beat : 16'h0000;
    assign row_strobe    = w_in_shift && (r_beat_cnt == c_LAST_BEAT) && w_last_word_of_row;
    assign row_addr      = r_row_cnt;
    assign pat_busy      = r_pat_busy;
    assign pat_idx       = r_pat_idx;
    assign seq_done      = r_seq_done;
    assign err_underrun  = r_err_underrun;
    assign err_req_busy  = r_err_req_busy;

    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            r_state        <= S_IDLE;
            r_word_reg     <= 64'h0;
            r_beat_cnt     <= 2'd0;
            r_word_cnt     <= 3'd0;
            r_row_cnt      <= 8'd0;
            r_prefetched   <= 1'b0;
            r_pat_idx      <= 32'd0;
            r_pat_busy     <= 1'b0;
            r_seq_done     <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_req_busy <= 1'b0;
        end else begin
            r_seq_done <= 1'b0;

            // A request during a transfer is dropped but remembered.
            if (pat_req && r_pat_busy) begin
                r_err_req_busy <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (pat_req) begin
                        r_pat_busy     <= 1'b1;
                        r_err_underrun <= 1'b0;
                        r_err_req_busy <= 1'b0;
                        r_beat_cnt     <= 2'd0;
                        r_word_cnt     <= 3'd0;
                        r_row_cnt      <= 8'd0;
                        r_prefetched   <= 1'b0;
                        if (w_seq_complete) begin
                            r_pat_idx <= 32'd0;
                        end
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (!outfifo_empty) begin
                        r_state <= S_LOAD;
                    end else if (!w_first_word) begin
                        // An empty FIFO before the first word is normal
                        // start-up latency; mid-pattern it is an underrun.
                        r_err_underrun <= 1'b1;
                    end
                end

                S_LOAD: begin
                    r_word_reg   <= outfifo_dout;
                    r_beat_cnt   <= 2'd0;
                    r_prefetched <= 1'b0;
                    r_state      <= S_SHIFT;
                end

                S_SHIFT: begin
                    r_beat_cnt <= r_beat_cnt + 2'd1;
                    if (w_prefetch_rd) begin
                        r_prefetched <= 1'b1;
                    end
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        if (w_last_word_of_pat) begin
                            r_state <= S_DONE;
                        end else begin
                            if (w_last_word_of_row) begin
                                r_word_cnt <= 3'd0;
                                r_row_cnt  <= r_row_cnt + 8'd1;
                            end else begin
                                r_word_cnt <= r_word_cnt + 3'd1;
                            end
                            if (r_prefetched) begin
                                // Prefetched data is valid now; switch words
                                // without leaving S_SHIFT.
                                r_word_reg   <= outfifo_dout;
                                r_prefetched <= 1'b0;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_pat_busy <= 1'b0;
                    r_row_cnt  <= 8'd0;
                    r_word_cnt <= 3'd0;
                    r_beat_cnt <= 2'd0;
                    r_pat_idx  <= r_pat_idx + 32'd1;
                    r_seq_done <= w_last_pat;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ROW_PARITY_EN
    // Running XOR of the row's beats; the output folds in the current beat
    // so the value is complete in the row_strobe cycle.
    logic [15:0] r_par_acc;

    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            r_par_acc <= 16'h0000;
        end else if (row_strobe) begin
            r_par_acc <= 16'h0000;
        end else if (w_in_shift) begin
            r_par_acc <= r_par_acc ^ w_beat;
        end
    end

    assign row_parity = r_par_acc ^ mask_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pat_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_pat_stream_out
// Description : Scoreboard bench for pat_stream_out. Each pattern request
//               pushes its expected beats into a queue; a forked monitor pops
//               and compares every valid beat. A forked FIFO model serves
//               preloaded pattern words with optional forced-empty stalls.
//               Define ROW_PARITY_EN to also cover row_parity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pat_stream_out;

    localparam int NWORDS   = 1408;
    localparam int PAT_CYC  = NWORDS * 4 + 3;
    localparam int WAIT_MAX = 20000;

    logic        clk = 1'b0;
    logic        fsm_rst_n;
    logic [31:0] Num_Pat;
    logic        pat_req;
    logic [63:0] outfifo_dout;
    logic        outfifo_empty;
    logic        outfifo_rd_en;
    logic [15:0] mask_data;
    logic        mask_valid;
    logic [7:0]  row_addr;
    logic        row_strobe;
    logic        pat_busy;
    logic [31:0] pat_idx;
    logic        seq_done;
    logic        err_underrun;
    logic        err_req_busy;
`ifdef ROW_PARITY_EN
    logic [15:0] row_parity;
`endif

    always #5 clk = ~clk;

    pat_stream_out dut (
        .clk           (clk),
        .fsm_rst_n     (fsm_rst_n),
        .Num_Pat       (Num_Pat),
        .pat_req       (pat_req),
        .outfifo_dout  (outfifo_dout),
        .outfifo_empty (outfifo_empty),
        .outfifo_rd_en (outfifo_rd_en),
        .mask_data     (mask_data),
        .mask_valid    (mask_valid),
        .row_addr      (row_addr),
        .row_strobe    (row_strobe),
        .pat_busy      (pat_busy),
        .pat_idx       (pat_idx),
        .seq_done      (seq_done),
        .err_underrun  (err_underrun),
        .err_req_busy  (err_req_busy)
`ifdef ROW_PARITY_EN
        ,
        .row_parity    (row_parity)
`endif
    );

    // FIFO model state
    logic [63:0] fifo_mem [0:NWORDS-1];
    int          rd_ptr;
    int          stall_idx;
    int          stall_left;

    assign outfifo_empty = (rd_ptr >= NWORDS) || ((rd_ptr == stall_idx) && (stall_left != 0));

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  row;
        logic        strobe;
        logic [15:0] par;
    } beat_t;

    beat_t exp_q[$];

    int n_checks;
    int n_errors;
    int valid_cnt;
    int strobe_cnt;
    int seq_cnt;
    int gap_run;
    int max_gap;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_ge(input string nm, input int act, input int lim);
        n_checks++;
        if (act < lim) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected at least %0d", nm, act, lim);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},      64'(outfifo_rd_en), 64'h0);
        check({tag, "_mask_data"},  64'(mask_data),     64'h0);
        check({tag, "_mask_valid"}, 64'(mask_valid),    64'h0);
        check({tag, "_row_addr"},   64'(row_addr),      64'h0);
        check({tag, "_row_strobe"}, 64'(row_strobe),    64'h0);
        check({tag, "_pat_busy"},   64'(pat_busy),      64'h0);
        check({tag, "_pat_idx"},    64'(pat_idx),       64'h0);
        check({tag, "_seq_done"},   64'(seq_done),      64'h0);
        check({tag, "_err_under"},  64'(err_underrun),  64'h0);
        check({tag, "_err_req"},    64'(err_req_busy),  64'h0);
`ifdef ROW_PARITY_EN
        check({tag, "_row_parity"}, 64'(row_parity),    64'h0);
`endif
    endtask

    // Word n (15:0) replicated four times; kind 1 adds the ordering word at
    // index 0 and two parity rows (rows 1 and 2).
    task automatic load_pattern(input int kind);
        logic [15:0] n16;
        for (int n = 0; n < NWORDS; n++) begin
            n16 = 16'(n);
            fifo_mem[n] = {4{n16}};
            if (kind == 1) begin
                if (n == 0)                 fifo_mem[n] = 64'h1111_2222_3333_4444;
                if (n >= 8 && n <= 23)      fifo_mem[n] = 64'hFFFF_0000_FFFF_0000;
                if (n == 23)                fifo_mem[n] = 64'hFFFF_0000_FFFF_0001;
            end
        end
        rd_ptr <= 0;
    endtask

    task automatic push_expected();
        logic [15:0] acc;
        logic [63:0] w;
        beat_t       e;
        acc = 16'h0;
        for (int n = 0; n < NWORDS; n++) begin
            w = fifo_mem[n];
            for (int b = 0; b < 4; b++) begin
                e.data   = w[63-16*b -: 16];
                e.row    = 8'(n / 8);
                e.strobe = ((n % 8) == 7) && (b == 3);
                acc      = acc ^ e.data;
                e.par    = acc;
                if (e.strobe) acc = 16'h0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_req();
        @(negedge clk);
        pat_req = 1'b1;
        @(negedge clk);
        pat_req = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (pat_busy && cycles < WAIT_MAX) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= WAIT_MAX) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle_timeout: pat_busy still %0b after %0d cycles", pat_busy, cycles);
        end
    endtask

    task automatic fifo_model();
        forever begin
            @(posedge clk);
            if (outfifo_rd_en && !outfifo_empty && rd_ptr < NWORDS) begin
                outfifo_dout <= fifo_mem[rd_ptr];
                rd_ptr       <= rd_ptr + 1;
            end
            // The stall only counts down while the stream is actually waiting.
            if (rd_ptr == stall_idx && stall_left != 0 && !mask_valid) begin
                stall_left <= stall_left - 1;
            end
        end
    endtask

    task automatic monitor();
        beat_t       e;
        logic        ok;
        logic [15:0] par_act;
        forever begin
            @(negedge clk);
            if (row_strobe) strobe_cnt++;
            if (seq_done)   seq_cnt++;
            if (!pat_busy) begin
                gap_run = 0;
            end else if (!mask_valid) begin
                gap_run++;
            end
            if (mask_valid) begin
                valid_cnt++;
                if (gap_run > max_gap) max_gap = gap_run;
                gap_run = 0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL beat_unexpected: got data=%h row=%0d with no beat expected", mask_data, row_addr);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (mask_data === e.data) && (row_addr === e.row) && (row_strobe === e.strobe);
`ifdef ROW_PARITY_EN
                    par_act = row_parity;
                    if (e.strobe && (row_parity !== e.par)) ok = 1'b0;
`else
                    par_act = e.par;
`endif
                    if (!ok) begin
                        n_errors++;
                        $display("FAIL beat: got data=%h row=%0d strobe=%0b par=%h, expected data=%h row=%0d strobe=%0b par=%h",
                                 mask_data, row_addr, row_strobe, par_act, e.data, e.row, e.strobe, e.par);
                    end
                end
            end
        end
    endtask

    initial begin
        int          cyc;
        int          v0;
        int          s0;
        int          q0;
        int          n;
        int          guard;
        logic [15:0] order_exp [4];

        order_exp[0] = 16'h1111;
        order_exp[1] = 16'h2222;
        order_exp[2] = 16'h3333;
        order_exp[3] = 16'h4444;

        fsm_rst_n    = 1'b0;
        Num_Pat      = 32'd0;
        pat_req      = 1'b0;
        outfifo_dout = 64'h0;
        stall_idx    = -1;
        stall_left   = 0;
        rd_ptr       = NWORDS;

        fork
            fifo_model();
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        fsm_rst_n = 1'b1;
        @(negedge clk);

        // ---- Pattern 1: Num_Pat=0, contiguous stream ----
        load_pattern(0);
        push_expected();
        max_gap = 0; v0 = valid_cnt; s0 = strobe_cnt; q0 = seq_cnt;
        pulse_req();
        check("p1_busy_after_req", 64'(pat_busy), 64'h1);
        wait_idle(cyc);
        check("p1_busy_cycles", 64'(cyc), 64'(PAT_CYC));
        check("p1_seq_done_at_end", 64'(seq_done), 64'h0);
        repeat (2) @(negedge clk);
        check("p1_valid_beats", 64'(valid_cnt - v0), 64'd5632);
        check("p1_row_strobes", 64'(strobe_cnt - s0), 64'd176);
        check("p1_max_gap", 64'(max_gap), 64'd2);
        check("p1_pat_idx", 64'(pat_idx), 64'd1);
        check("p1_seq_count", 64'(seq_cnt - q0), 64'd0);
        check("p1_err_underrun", 64'(err_underrun), 64'h0);
        check("p1_err_req_busy", 64'(err_req_busy), 64'h0);
        check("p1_row_addr_idle", 64'(row_addr), 64'h0);
        check("p1_queue_drained", 64'(exp_q.size()), 64'd0);

        // ---- Pattern 2: last of the 2-pattern sequence ----
        load_pattern(0);
        push_expected();
        q0 = seq_cnt;
        pulse_req();
        wait_idle(cyc);
        check("p2_seq_done_at_end", 64'(seq_done), 64'h1);
        check("p2_pat_idx", 64'(pat_idx), 64'd2);
        repeat (2) @(negedge clk);
        check("p2_seq_count", 64'(seq_cnt - q0), 64'd1);
        check("p2_queue_drained", 64'(exp_q.size()), 64'd0);

        // ---- Pattern 3: sequence restart, beat ordering, row parity ----
        load_pattern(1);
        push_expected();
        q0 = seq_cnt;
        pulse_req();
        check("p3_pat_idx_restart", 64'(pat_idx), 64'd0);
        guard = 0;
        while (!mask_valid && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("p3_order_beat%0d", k), 64'(mask_data), 64'(order_exp[k]));
            @(negedge clk);
        end
`ifdef ROW_PARITY_EN
        guard = 0;
        while (!(row_strobe && row_addr == 8'd1) && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check("p3_parity_row1", 64'(row_parity), 64'h0000);
        @(negedge clk);
        guard = 0;
        while (!(row_strobe && row_addr == 8'd2) && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check("p3_parity_row2", 64'(row_parity), 64'h0001);
`endif
        wait_idle(cyc);
        check("p3_seq_done_at_end", 64'(seq_done), 64'h0);
        check("p3_pat_idx", 64'(pat_idx), 64'd1);
        repeat (2) @(negedge clk);
        check("p3_seq_count", 64'(seq_cnt - q0), 64'd0);
        check("p3_queue_drained", 64'(exp_q.size()), 64'd0);

        // ---- Pattern 4: FIFO empty for 10 cycles at row 5 word 3 ----
        Num_Pat = 32'd10;
        load_pattern(0);
        push_expected();
        stall_idx  = 5 * 8 + 3;
        stall_left <= 10;
        max_gap = 0;
        pulse_req();
        wait_idle(cyc);
        repeat (2) @(negedge clk);
        stall_idx = -1;
        check_ge("p4_stall_gap", max_gap, 10);
        check("p4_err_underrun", 64'(err_underrun), 64'h1);
        check("p4_err_req_busy", 64'(err_req_busy), 64'h0);
        check("p4_pat_idx", 64'(pat_idx), 64'd2);
        check("p4_queue_drained", 64'(exp_q.size()), 64'd0);

        // ---- Pattern 5: pat_req at beat 100 is ignored ----
        load_pattern(0);
        push_expected();
        v0 = valid_cnt;
        pulse_req();
        check("p5_underrun_cleared", 64'(err_underrun), 64'h0);
        n = 0;
        guard = 0;
        while (n < 100 && guard < 1000) begin
            guard++;
            @(negedge clk);
            if (mask_valid) n++;
        end
        pat_req = 1'b1;
        @(negedge clk);
        pat_req = 1'b0;
        check("p5_err_req_busy_set", 64'(err_req_busy), 64'h1);
        wait_idle(cyc);
        repeat (2) @(negedge clk);
        check("p5_valid_beats", 64'(valid_cnt - v0), 64'd5632);
        check("p5_pat_idx", 64'(pat_idx), 64'd3);
        check("p5_err_req_busy_sticky", 64'(err_req_busy), 64'h1);
        check("p5_queue_drained", 64'(exp_q.size()), 64'd0);

        // ---- Pattern 6: reset at row 50, then restart ----
        load_pattern(0);
        push_expected();
        pulse_req();
        check("p6_err_req_busy_cleared", 64'(err_req_busy), 64'h0);
        guard = 0;
        while (row_addr != 8'd50 && guard < 3000) begin
            guard++;
            @(negedge clk);
        end
        check("p6_reached_row50", 64'(row_addr), 64'd50);
        #2;
        fsm_rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        @(negedge clk);
        fsm_rst_n = 1'b1;
        @(negedge clk);
        check("p6_pat_idx_after_rst", 64'(pat_idx), 64'd0);
        load_pattern(0);
        push_expected();
        pulse_req();
        check("p6_restart_row", 64'(row_addr), 64'd0);
        check("p6_restart_idx", 64'(pat_idx), 64'd0);
        wait_idle(cyc);
        check("p6_busy_cycles", 64'(cyc), 64'(PAT_CYC));
        repeat (2) @(negedge clk);
        check("p6_pat_idx", 64'(pat_idx), 64'd1);
        check("p6_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
